dds_rom_arbiter: RTL and testbench
==================================

DDS_ROM_ARBITER -- requirements
Module: dds_rom_arbiter

Interface
REQ-001 SHALL have parameter ROM_ADDR_WIDTH, default 12, phase address width.
REQ-002 SHALL have parameter ROM_WIDTH, default 18, signed sample width.
REQ-003 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester lookup request.
REQ-007 SHALL have port req_addr  input  N_REQ*ROM_ADDR_WIDTH  per-requester phase; slice i is requester i.
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester acceptance; one-hot or zero.
REQ-009 SHALL have port resp_valid  output  1  response sample valid.
REQ-010 SHALL have port resp_ready  input  1  downstream accepts response.
REQ-011 SHALL have port resp_data  output  ROM_WIDTH  signed minus-sine sample.
REQ-012 SHALL have port resp_id  output  clog2(N_REQ)  index of the requester that owns resp_data.
REQ-013 SHALL have port busy  output  1  high while resp_valid is high or any req_valid is high.

Function
REQ-014 SHALL share one symmetric quarter-wave minus-sine ROM (1-cycle registered, ce-gated) among all requesters.
REQ-015 SHALL define stall = resp_valid AND NOT resp_ready.
REQ-016 SHALL, when not stalled, grant exactly one valid requester per cycle by round-robin from pointer rr_ptr.
REQ-017 SHALL search from rr_ptr upward modulo N_REQ; the first requester with req_valid high wins.
REQ-018 SHALL drive req_ready[i] = grant[i] AND NOT stall (combinational from req_valid, rr_ptr, stall).
REQ-019 SHALL treat a transfer as accepted when req_valid[i] AND req_ready[i].
REQ-020 SHALL on acceptance from i set rr_ptr = (i+1) mod N_REQ; SHALL leave rr_ptr unchanged otherwise.
REQ-021 SHALL present the granted req_addr to the ROM and assert ROM ce when not stalled.
REQ-022 SHALL assert resp_valid, resp_data and resp_id exactly one cycle after acceptance (latency 1).
REQ-023 SHALL hold resp_data and resp_id stable, with ROM ce low, while stalled.
REQ-024 SHALL deassert resp_valid in the cycle after resp_ready is seen with no new acceptance.
REQ-025 SHALL sustain one response per cycle when resp_ready stays high (back-to-back acceptance).
REQ-026 SHALL not drop or duplicate a response; each accepted request yields exactly one resp_valid&resp_ready beat.
REQ-027 SHALL not require req_valid to be held; a requester withdrawing req_valid before acceptance loses no state.
REQ-028 SHALL wrap rr_ptr from N_REQ-1 to 0.
REQ-029 SHALL ignore req_addr of non-granted requesters.

Reset
REQ-030 SHALL, while rst is low at a clock edge, clear resp_valid, resp_data (0), resp_id (0), rr_ptr (0); req_ready SHALL be 0 during reset.
REQ-031 SHALL discard any in-flight response when reset asserts mid-operation; first grant after release goes to lowest valid index.

Structure
REQ-032 SHALL place ROM_ADDR_WIDTH/ROM_WIDTH defaults and the id-width function in the shared DDS package.
REQ-033 SHALL instantiate exactly one sub-module, the existing symmetric quarter-wave minus-sine ROM, and one round-robin grant function.

Verification
REQ-034 Single request i=0, addr 0, resp_ready=1 -> next cycle resp_valid=1, resp_id=0, resp_data=0.
REQ-035 All four requesting continuously, resp_ready=1 -> grant order 0,1,2,3,0,... one response per cycle.
REQ-036 Req 2 addr 1024, resp_ready=0 for 3 cycles -> resp_data/resp_id frozen, req_ready all 0, no new grant.
REQ-037 Addr 3072 vs addr 1024 on same requester -> resp_data values are exact negatives of each other.
REQ-038 rst low for 1 cycle while resp_valid=1 -> resp_valid=0, rr_ptr=0; next request from 1 and 3 grants 1.
REQ-039 Random valid/ready traffic, 10k cycles -> scoreboard: response count = acceptance count, ids in order.

Source files
------------

// File: rtl/dds_rom_arbiter_pkg.sv
// Shared DDS definitions: default widths, id-width helper and the
// elaboration-time quarter-wave sine generator used to fill the ROM.
package dds_rom_arbiter_pkg;

  localparam int unsigned DDS_ROM_ADDR_WIDTH = 12;
  localparam int unsigned DDS_ROM_WIDTH      = 18;

  // pi/2 in Q30 fixed point
  localparam longint PI_HALF_Q30 = 64'sd1686629713;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Round(amp * sin(pi/2 * idx / 2**qbits)) with amp = 2**(width-1)-1.
  // Integer Taylor series in Q30 so the table needs no real arithmetic.
  function automatic longint quarter_sine(input int unsigned idx,
                                          input int unsigned qbits,
                                          input int unsigned width);
    longint x;
    longint term;
    longint sum;
    longint amp;
    longint s;
    x    = (longint'(idx) * PI_HALF_Q30) >>> qbits;
    term = x;
    sum  = x;
    for (int unsigned k = 1; k <= 8; k++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = (64'sd1 <<< (width - 1)) - 64'sd1;
    s   = (sum * amp + (64'sd1 <<< 29)) >>> 30;
    if (s > amp) s = amp;
    if (s < 0)   s = 0;
    return s;
  endfunction

endpackage

// File: rtl/dds_rom_arbiter_rom.sv
// Symmetric quarter-wave minus-sine ROM: one quarter table (inclusive of
// the peak entry) unfolded by mirror and negation, 1-cycle registered, ce-gated.
module dds_rom_arbiter_rom
  import dds_rom_arbiter_pkg::*;
#(
  parameter int unsigned ROM_ADDR_WIDTH = DDS_ROM_ADDR_WIDTH,
  parameter int unsigned ROM_WIDTH      = DDS_ROM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic [ROM_ADDR_WIDTH-1:0]   addr,
  output logic signed [ROM_WIDTH-1:0] data
);

  localparam int unsigned QBITS  = ROM_ADDR_WIDTH - 2;
  localparam int unsigned QDEPTH = 2 ** QBITS;
  localparam logic [QBITS:0] QFULL = {1'b1, {QBITS{1'b0}}};

  logic signed [ROM_WIDTH-1:0] tab [0:QDEPTH];
  logic [1:0]       quad;
  logic [QBITS-1:0] off;
  logic [QBITS:0]   idx;
  logic             neg;

  for (genvar g = 0; g <= int'(QDEPTH); g++) begin : g_tab
    localparam logic signed [ROM_WIDTH-1:0] V =
      ROM_WIDTH'(quarter_sine(g, QBITS, ROM_WIDTH));
    assign tab[g] = V;
  end

  // Fold the phase into the quarter table; first half-cycle is negative.
  always_comb begin
    quad = addr[ROM_ADDR_WIDTH-1 -: 2];
    off  = addr[QBITS-1:0];
    idx  = quad[0] ? (QFULL - {1'b0, off}) : {1'b0, off};
    neg  = ~quad[1];
  end

  // Registered, clock-enabled sample output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data <= '0;
    end else if (ce) begin
      data <= neg ? -tab[idx] : tab[idx];
    end
  end

endmodule

// File: rtl/dds_rom_arbiter.sv
// Round-robin arbiter sharing one minus-sine ROM among N_REQ requesters
// with a valid/ready response port (latency 1, stall holds the response).
module dds_rom_arbiter
  import dds_rom_arbiter_pkg::*;
#(
  parameter int unsigned ROM_ADDR_WIDTH = DDS_ROM_ADDR_WIDTH,
  parameter int unsigned ROM_WIDTH      = DDS_ROM_WIDTH,
  parameter int unsigned N_REQ          = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ*ROM_ADDR_WIDTH-1:0]   req_addr,
  output logic [N_REQ-1:0]                  req_ready,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic signed [ROM_WIDTH-1:0]       resp_data,
  output logic [id_width(N_REQ)-1:0]        resp_id,
  output logic                              busy
);

  localparam int unsigned IDW = id_width(N_REQ);

  logic [IDW-1:0]            rr_ptr;
  logic [IDW-1:0]            gnt_idx;
  logic [IDW-1:0]            next_ptr;
  logic [N_REQ-1:0]          grant;
  logic                      stall;
  logic                      accept;
  logic                      rom_ce;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr;

  // First valid requester at or above ptr, wrapping modulo N_REQ.
  function automatic logic [N_REQ-1:0] rr_grant(input logic [N_REQ-1:0] v,
                                                input logic [IDW-1:0]   ptr);
    logic [N_REQ-1:0] g;
    logic [IDW-1:0]   j;
    g = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = IDW'((32'(ptr) + k) % N_REQ);
      if (v[j] && (g == '0)) g[j] = 1'b1;
    end
    return g;
  endfunction

  // Grant, handshake, ROM address mux and pointer advance.
  always_comb begin
    stall     = resp_valid & ~resp_ready;
    grant     = rr_grant(req_valid, rr_ptr);
    req_ready = (stall || !rst) ? '0 : grant;
    accept    = |(req_valid & req_ready);
    rom_ce    = ~stall;
    gnt_idx   = '0;
    rom_addr  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        gnt_idx  = IDW'(k);
        rom_addr = req_addr[k*ROM_ADDR_WIDTH +: ROM_ADDR_WIDTH];
      end
    end
    next_ptr = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    busy     = resp_valid | (|req_valid);
  end

  // Response valid/id tracking and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      rr_ptr     <= '0;
    end else begin
      if (!stall) begin
        resp_valid <= accept;
        resp_id    <= gnt_idx;
      end
      if (accept) rr_ptr <= next_ptr;
    end
  end

  dds_rom_arbiter_rom #(
    .ROM_ADDR_WIDTH(ROM_ADDR_WIDTH),
    .ROM_WIDTH     (ROM_WIDTH)
  ) u_rom (
    .clk (clk),
    .rst (rst),
    .ce  (rom_ce),
    .addr(rom_addr),
    .data(resp_data)
  );

endmodule

// File: tb/tb_dds_rom_arbiter.sv
// Self-checking bench for dds_rom_arbiter: directed vector table, hand
// sequences for stall/reset/withdrawal, and random traffic with a model.
`timescale 1ns/1ps
module tb_dds_rom_arbiter;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [3:0]         req_valid = '0;
  logic [47:0]        req_addr = '0;
  logic [3:0]         req_ready;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic signed [17:0] resp_data;
  logic [1:0]         resp_id;
  logic               busy;

  int   errors = 0;
  int   checks = 0;
  logic last_rv = 1'b0;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [47:0] a;
    logic        rr;
    logic [3:0]  er;
    logic        erv;
    logic [1:0]  eid;
    int          ed;
  } vec_t;

  vec_t tv [14];

  // Known sample points: amp = 131071
  int addr_tab [9] = '{0, 1, 512, 1024, 1536, 2048, 2560, 3072, 3584};
  int val_tab  [9] = '{0, -201, -92681, -131071, -92681, 0, 92681, 131071, 92681};

  // random-phase model state
  logic [3:0] rv_v;
  logic       rv_rr;
  logic [3:0] rv_er;
  int         sel [4];
  int         mptr;
  logic       mv;
  int         mid;
  int         mdata;
  int         gi;
  int         accepts;
  int         beats;

  always #5 clk = ~clk;

  dds_rom_arbiter #(
    .ROM_ADDR_WIDTH(12),
    .ROM_WIDTH     (18),
    .N_REQ         (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_id   (resp_id),
    .busy      (busy)
  );

  function automatic logic [47:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
  endfunction

  // Rotate-and-scan reference for the round-robin pick; -1 when none valid.
  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    logic [7:0] d;
    d = {v, v} >> ptr;
    for (int b = 0; b < 4; b++) begin
      if (d[b]) return (b + ptr) % 4;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check handshake at +2, outputs after next edge.
  task automatic apply(input string name, input logic r, input logic [3:0] v,
                       input logic [47:0] a, input logic rr, input logic [3:0] er,
                       input logic erv, input logic [1:0] eid, input int ed);
    rst        = r;
    req_valid  = v;
    req_addr   = a;
    resp_ready = rr;
    #1;
    check({name, ".req_ready"}, int'(req_ready), int'(er));
    check({name, ".busy"}, int'(busy), int'(last_rv | (|v)));
    @(posedge clk);
    #1;
    check({name, ".resp_valid"}, int'(resp_valid), int'(erv));
    if (erv || !r) begin
      check({name, ".resp_id"}, int'(resp_id), int'(eid));
      check({name, ".resp_data"}, int'(resp_data), ed);
    end
    last_rv = erv;
  endtask

  initial begin
    // reset, single request, idle drop, round robin with wrap, negation pairs
    tv[0]  = '{1'b0, 4'b1111, pk(0, 0, 0, 0),          1'b1, 4'b0000, 1'b0, 2'd0, 0};
    tv[1]  = '{1'b0, 4'b0000, pk(0, 0, 0, 0),          1'b1, 4'b0000, 1'b0, 2'd0, 0};
    tv[2]  = '{1'b1, 4'b0001, pk(0, 0, 0, 0),          1'b1, 4'b0001, 1'b1, 2'd0, 0};
    tv[3]  = '{1'b1, 4'b0000, pk(0, 0, 0, 0),          1'b1, 4'b0000, 1'b0, 2'd0, 0};
    tv[4]  = '{1'b1, 4'b1111, pk(1, 512, 3072, 1024),  1'b1, 4'b0010, 1'b1, 2'd1, 131071};
    tv[5]  = '{1'b1, 4'b1111, pk(1, 512, 3072, 1024),  1'b1, 4'b0100, 1'b1, 2'd2, -92681};
    tv[6]  = '{1'b1, 4'b1111, pk(1, 512, 3072, 1024),  1'b1, 4'b1000, 1'b1, 2'd3, -201};
    tv[7]  = '{1'b1, 4'b1111, pk(1, 512, 3072, 1024),  1'b1, 4'b0001, 1'b1, 2'd0, -131071};
    tv[8]  = '{1'b1, 4'b1111, pk(1, 512, 3072, 1024),  1'b1, 4'b0010, 1'b1, 2'd1, 131071};
    tv[9]  = '{1'b1, 4'b0001, pk(0, 0, 0, 3072),       1'b1, 4'b0001, 1'b1, 2'd0, 131071};
    tv[10] = '{1'b1, 4'b0100, pk(0, 2048, 0, 0),       1'b1, 4'b0100, 1'b1, 2'd2, 0};
    tv[11] = '{1'b1, 4'b0011, pk(0, 0, 3584, 2560),    1'b1, 4'b0001, 1'b1, 2'd0, 92681};
    tv[12] = '{1'b1, 4'b0011, pk(0, 0, 3584, 2560),    1'b1, 4'b0010, 1'b1, 2'd1, 92681};
    tv[13] = '{1'b1, 4'b0000, pk(0, 0, 0, 0),          1'b1, 4'b0000, 1'b0, 2'd0, 0};

    rst = 1'b0;
    @(posedge clk);
    #1;
    last_rv = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apply($sformatf("tv%0d", i), tv[i].r, tv[i].v, tv[i].a, tv[i].rr,
            tv[i].er, tv[i].erv, tv[i].eid, tv[i].ed);
    end

    // stall: response frozen, no grant while resp_ready low
    apply("stall0", 1'b1, 4'b0100, pk(0, 1024, 0, 0), 1'b0, 4'b0100, 1'b1, 2'd2, -131071);
    for (int i = 1; i <= 3; i++) begin
      apply($sformatf("stall%0d", i), 1'b1, 4'b1111, pk(3072, 3072, 3072, 3072), 1'b0,
            4'b0000, 1'b1, 2'd2, -131071);
    end
    apply("stall_rel", 1'b1, 4'b0000, pk(0, 0, 0, 0), 1'b1, 4'b0000, 1'b0, 2'd0, 0);
    apply("idle",      1'b1, 4'b0000, pk(0, 0, 0, 0), 1'b1, 4'b0000, 1'b0, 2'd0, 0);

    // reset while a response is pending and rr_ptr is 3
    apply("rst_pre",  1'b1, 4'b0100, pk(0, 3072, 0, 0),   1'b0, 4'b0100, 1'b1, 2'd2, 131071);
    apply("rst_mid",  1'b0, 4'b1010, pk(512, 0, 3072, 0), 1'b0, 4'b0000, 1'b0, 2'd0, 0);
    apply("rst_post", 1'b1, 4'b1010, pk(512, 0, 3072, 0), 1'b1, 4'b0010, 1'b1, 2'd1, 131071);

    // withdrawal of an unaccepted request leaves the pointer alone
    apply("wd0", 1'b1, 4'b0100, pk(0, 1536, 0, 0), 1'b0, 4'b0000, 1'b1, 2'd1, 131071);
    apply("wd1", 1'b1, 4'b0000, pk(0, 0, 0, 0),    1'b1, 4'b0000, 1'b0, 2'd0, 0);
    apply("wd2", 1'b1, 4'b1100, pk(0, 1536, 0, 0), 1'b1, 4'b0100, 1'b1, 2'd2, -92681);
    apply("wd3", 1'b1, 4'b0000, pk(0, 0, 0, 0),    1'b1, 4'b0000, 1'b0, 2'd0, 0);

    // random traffic against a reference model
    apply("rnd_rst", 1'b0, 4'b0000, pk(0, 0, 0, 0), 1'b1, 4'b0000, 1'b0, 2'd0, 0);
    mptr = 0; mv = 1'b0; mid = 0; mdata = 0; accepts = 0; beats = 0;
    for (int cyc = 0; cyc < 10004; cyc++) begin
      check("rnd.resp_valid", int'(resp_valid), int'(mv));
      if (mv) begin
        check("rnd.resp_id", int'(resp_id), mid);
        check("rnd.resp_data", int'(resp_data), mdata);
      end
      if (cyc < 10000) begin
        rv_v  = 4'($urandom);
        rv_rr = ($urandom_range(0, 3) != 0);
      end else begin
        rv_v  = 4'b0000;
        rv_rr = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        sel[k] = $urandom_range(0, 8);
        req_addr[k*12 +: 12] = 12'(addr_tab[sel[k]]);
      end
      rst        = 1'b1;
      req_valid  = rv_v;
      resp_ready = rv_rr;
      #1;
      gi    = rr_pick(rv_v, mptr);
      rv_er = '0;
      if (!(mv && !rv_rr) && gi >= 0) rv_er[gi] = 1'b1;
      check("rnd.req_ready", int'(req_ready), int'(rv_er));
      if (resp_valid && resp_ready) beats++;
      if (!(mv && !rv_rr)) begin
        mv = (rv_er != 4'b0000);
        if (mv) begin
          mid   = gi;
          mdata = val_tab[sel[gi]];
          mptr  = (gi + 1) % 4;
          accepts++;
        end
      end
      @(posedge clk);
      #1;
    end
    check("rnd.beats_vs_accepts", beats, accepts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
